// File: rtl/clause_queue.sv
// Per-engine clause FIFO behind the distribution unit; optional high-water mark via CLAUSE_QUEUE_WATERMARK_EN.
// Latency: a clause pushed in cycle N is on clause_out in cycle N+1 (show-ahead, no same-cycle bypass).
// Backpressure: full_out rises at DEPTH-SKID entries; grants into a truly full queue are dropped and flagged.
module clause_queue #(
  parameter int DEPTH           = 16,
  parameter int VARIABLE_LENGTH = 11,
  parameter int CLA_LENGTH      = 3,
  parameter int SKID            = 2
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  grant_in,
  input  logic [CLA_LENGTH*VARIABLE_LENGTH-1:0] clause_in,
  input  logic                                  flush_in,
  input  logic                                  pop_in,
  output logic                                  full_out,
  output logic [CLA_LENGTH*VARIABLE_LENGTH-1:0] clause_out,
  output logic                                  clause_valid_out,
  output logic [$clog2(DEPTH):0]                count_out,
`ifdef CLAUSE_QUEUE_WATERMARK_EN
  output logic [$clog2(DEPTH):0]                max_count_out,
`endif
  output logic                                  overflow_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = CLA_LENGTH * VARIABLE_LENGTH;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          pop_fire;
  logic          push_fire;

  // Handshake decode: a full queue still takes a grant when the head leaves in the same cycle
  always_comb begin
    pop_fire   = pop_in & (count != '0);
    push_fire  = grant_in & ((count < CW'(DEPTH)) | pop_fire);
    count_next = count + CW'(push_fire) - CW'(pop_fire);
  end

  assign clause_out       = mem[rd_ptr];
  assign clause_valid_out = (count != '0);
  assign count_out        = count;
  // Decoded from the count register only, so there is no input-to-output path
  assign full_out         = (count >= CW'(DEPTH - SKID));

  // Storage write; contents need no reset since valid is governed by count
  always_ff @(posedge clock) begin
    if (!reset && !flush_in && push_fire) begin
      mem[wr_ptr] <= clause_in;
    end
  end

  // Pointer, occupancy and sticky overflow state; flush discards any concurrent push/pop
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      overflow_out <= 1'b0;
    end else if (flush_in) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      overflow_out <= 1'b0;
    end else begin
      if (push_fire) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
      if (grant_in && !push_fire) begin
        overflow_out <= 1'b1;
      end
    end
  end

`ifdef CLAUSE_QUEUE_WATERMARK_EN
  logic [CW-1:0] count_eff;
  assign count_eff = flush_in ? '0 : count_next;

  // High-water mark of occupancy; survives flush so it reflects the worst case since reset
  always_ff @(posedge clock) begin
    if (reset) begin
      max_count_out <= '0;
    end else if (count_eff > max_count_out) begin
      max_count_out <= count_eff;
    end
  end
`endif

endmodule

// File: tb/tb_clause_queue.sv
// Self-checking bench for clause_queue: vector table, corner-case sequences and randomized traffic.
// Every cycle is compared against a queue-based reference model; key points also against constants.
// Inputs change 1 ns after the rising edge and outputs are sampled there too.
module tb_clause_queue;

  localparam int DEPTH = 16;
  localparam int SKID  = 2;
  localparam int DW    = 33;
  localparam int CW    = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          grant_in;
  logic [DW-1:0] clause_in;
  logic          flush_in;
  logic          pop_in;
  logic          full_out;
  logic [DW-1:0] clause_out;
  logic          clause_valid_out;
  logic [CW-1:0] count_out;
  logic          overflow_out;
`ifdef CLAUSE_QUEUE_WATERMARK_EN
  logic [CW-1:0] max_count_out;
`endif

  clause_queue #(.DEPTH(DEPTH), .VARIABLE_LENGTH(11), .CLA_LENGTH(3), .SKID(SKID)) dut (
    .clock            (clock),
    .reset            (reset),
    .grant_in         (grant_in),
    .clause_in        (clause_in),
    .flush_in         (flush_in),
    .pop_in           (pop_in),
    .full_out         (full_out),
    .clause_out       (clause_out),
    .clause_valid_out (clause_valid_out),
    .count_out        (count_out),
`ifdef CLAUSE_QUEUE_WATERMARK_EN
    .max_count_out    (max_count_out),
`endif
    .overflow_out     (overflow_out)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: a plain queue of clauses plus the sticky flag and high-water mark
  logic [DW-1:0] mq[$];
  bit            movf;
  int            mx;

  typedef struct {
    logic          g;
    logic          p;
    logic          f;
    logic [DW-1:0] d;
    int            cnt;
    logic          vld;
    logic [DW-1:0] head;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("count", 64'(count_out), 64'(mq.size()));
    chk("valid", 64'(clause_valid_out), 64'(mq.size() != 0));
    chk("full", 64'(full_out), 64'(mq.size() >= DEPTH - SKID));
    chk("overflow", 64'(overflow_out), 64'(movf));
    if (mq.size() != 0) chk("head", 64'(clause_out), 64'(mq[0]));
`ifdef CLAUSE_QUEUE_WATERMARK_EN
    chk("max_count", 64'(max_count_out), 64'(mx));
`endif
  endtask

  // One clock: drive, let the edge happen, advance the model, then compare
  task automatic step(input logic g, input logic p, input logic f, input logic [DW-1:0] d);
    bit pop_ok, push_ok;
    grant_in  = g;
    pop_in    = p;
    flush_in  = f;
    clause_in = d;
    @(posedge clock);
    pop_ok  = p && (mq.size() > 0);
    push_ok = g && ((mq.size() < DEPTH) || pop_ok);
    if (f) begin
      mq.delete();
      movf = 0;
    end else begin
      if (g && !push_ok) movf = 1;
      if (pop_ok) void'(mq.pop_front());
      if (push_ok) mq.push_back(d);
    end
    if (mq.size() > mx) mx = mq.size();
    #1;
    model_check();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    grant_in  = 1'b0;
    pop_in    = 1'b0;
    flush_in  = 1'b0;
    clause_in = '0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    mq.delete();
    movf = 0;
    mx   = 0;
    chk("rst_count", 64'(count_out), 64'd0);
    chk("rst_valid", 64'(clause_valid_out), 64'd0);
    chk("rst_full", 64'(full_out), 64'd0);
    chk("rst_overflow", 64'(overflow_out), 64'd0);
  endtask

  initial begin
    logic [63:0] rnd;

    //        g     p     f     data      cnt vld   head
    tbl[0] = '{1'b1, 1'b0, 1'b0, 33'h001, 1, 1'b1, 33'h001};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 33'h002, 2, 1'b1, 33'h001};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 33'h003, 3, 1'b1, 33'h001};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 33'h000, 2, 1'b1, 33'h002};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 33'h004, 2, 1'b1, 33'h003};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 33'h000, 1, 1'b1, 33'h004};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 33'h000, 0, 1'b0, 33'h000};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 33'h000, 0, 1'b0, 33'h000};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 33'h005, 0, 1'b0, 33'h000};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 33'h006, 1, 1'b1, 33'h006};

    do_reset();

    // Vector table: basic push/pop/empty-pop/flush behaviour with fixed expectations
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].g, tbl[i].p, tbl[i].f, tbl[i].d);
      chk("tbl_count", 64'(count_out), 64'(tbl[i].cnt));
      chk("tbl_valid", 64'(clause_valid_out), 64'(tbl[i].vld));
      chk("tbl_full", 64'(full_out), 64'd0);
      if (tbl[i].vld) chk("tbl_head", 64'(clause_out), 64'(tbl[i].head));
    end

    // Fill to the skid threshold, then into the skid slots, then overflow
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 1'b0, 1'b0, 33'h100 + 33'(i));
      chk("fill_full", 64'(full_out), 64'(i == 13));
    end
    step(1'b1, 1'b0, 1'b0, 33'h10E);
    step(1'b1, 1'b0, 1'b0, 33'h10F);
    chk("skid_count", 64'(count_out), 64'd16);
    chk("skid_overflow", 64'(overflow_out), 64'd0);
    step(1'b1, 1'b0, 1'b0, 33'h1FF);
    chk("ovf_count", 64'(count_out), 64'd16);
    chk("ovf_flag", 64'(overflow_out), 64'd1);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", 64'(clause_out), 64'h100 + 64'(i));
      step(1'b0, 1'b1, 1'b0, '0);
    end
    chk("drain_empty", 64'(clause_valid_out), 64'd0);
    chk("drain_ovf_sticky", 64'(overflow_out), 64'd1);

    // Full queue with simultaneous grant and pop: both fire
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 33'h200 + 33'(i));
    step(1'b1, 1'b1, 1'b0, 33'h777);
    chk("fullpp_count", 64'(count_out), 64'd16);
    chk("fullpp_ovf", 64'(overflow_out), 64'd0);
    for (int i = 0; i < 16; i++) begin
      chk("fullpp_order", 64'(clause_out), (i == 15) ? 64'h777 : 64'h201 + 64'(i));
      step(1'b0, 1'b1, 1'b0, '0);
    end

    // Continuous push+pop for 40 cycles wraps the pointers several times
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 33'h300 + 33'(i));
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 1'b0, 33'h400 + 33'(i));
      chk("stream_count", 64'(count_out), 64'd4);
    end

    // Flush with 5 entries and overflow set, concurrent grant is discarded
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 33'h500 + 33'(i));
    step(1'b1, 1'b0, 1'b0, 33'h5FF);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b0, '0);
    chk("preflush_count", 64'(count_out), 64'd5);
    chk("preflush_ovf", 64'(overflow_out), 64'd1);
    step(1'b1, 1'b0, 1'b1, 33'h5A5);
    chk("flush_count", 64'(count_out), 64'd0);
    chk("flush_valid", 64'(clause_valid_out), 64'd0);
    chk("flush_full", 64'(full_out), 64'd0);
    chk("flush_ovf", 64'(overflow_out), 64'd0);
    step(1'b1, 1'b0, 1'b0, 33'h0AB);
    chk("postflush_head", 64'(clause_out), 64'h0AB);
    chk("postflush_count", 64'(count_out), 64'd1);

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      rnd = {$urandom(), $urandom()};
      step(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 99) < 2), rnd[DW-1:0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
